ps2_dev_tx: RTL and testbench
=============================

Name: ps2_dev_tx

Overview:
Parametrised multi-channel PS/2 device-side transmitter. It generalises the keyboard/mouse emulation into CHANNELS independent channels. Each channel has its own FIFO of configurable depth and a PS/2 serialiser. Every channel shares one clk_sys-derived PS/2 bit clock. New behaviour: true full/empty flags, a fill level, sticky overflow, per-channel flush, and host-inhibit with abort-and-retransmit. Sits between the SPI command decoder (byte writers) and core-side PS/2 consumers.

Parameters:
CHANNELS, 2, number of independent PS/2 channels (ch0 = keyboard, ch1 = mouse by convention)
FIFO_BITS, 3, log2 FIFO depth per channel; depth = 2**FIFO_BITS entries, all usable
PS2DIV, 100, bit-clock divider; PS/2 clock period = 2*(PS2DIV+1) clk_sys cycles

Ports:
clk_sys  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
wr  in  CHANNELS  per-channel byte write strobe, one byte per cycle high
wr_data  in  8*CHANNELS  per-channel byte; channel i uses [8i+7:8i]
flush  in  CHANNELS  per-channel synchronous flush
inhibit  in  CHANNELS  host inhibit (host holding clock low), level
ps2_clk  out  CHANNELS  PS/2 clock per channel
ps2_data  out  CHANNELS  PS/2 data per channel
fifo_full  out  CHANNELS  level == 2**FIFO_BITS
fifo_empty  out  CHANNELS  level == 0
fifo_level  out  (FIFO_BITS+1)*CHANNELS  entries held; channel i in [(FIFO_BITS+1)(i+1)-1:(FIFO_BITS+1)i]
overflow  out  CHANNELS  sticky: write dropped while full
busy  out  CHANNELS  tx state != IDLE

Behaviour:
- Reset (async, reset_n=0): divider cnt=0, clk_ps2=0, all states IDLE, pointers/levels 0, overflow 0, ps2_data=1, ps2_clk=1, fifo_empty=1, fifo_full=0.
- Divider: cnt increments each cycle. At cnt==PS2DIV, clk_ps2 toggles and cnt<=0. tick = registered 0->1 edge of clk_ps2: one-cycle pulse every 2*(PS2DIV+1) cycles. The divider is shared by all channels and never stops.
- ps2_clk[i] = clk_ps2 | (state==IDLE) | inhibit[i]. The clock is high while idle or inhibited.
- FIFO write: wr[i] & !full -> store byte, level+1, next cycle. wr[i] & full -> byte dropped, overflow[i]<=1.
- FIFO pop: head read in place. The read pointer advances and level decrements only when a frame completes (state 11). A write and a pop in the same cycle leave level unchanged.
- State machine, advancing only on tick, per channel:
  - IDLE(0): if !empty & !inhibit, latch head byte, parity<=1, ps2_data<=0 (start bit), go to 1.
  - States 1..8: ps2_data<=byte[0]; shift byte right; toggle parity when byte[0]=1; state+1.
  - State 9: ps2_data<=parity (odd parity); go to 10.
  - State 10: ps2_data<=1 (stop); go to 11.
  - State 11: pop FIFO; go to IDLE.
  - Back-to-back frames: the next start bit goes out on the tick after IDLE is re-entered.
- Inhibit: sampled on tick.
  - In states 1..10 with inhibit=1: abort; state<=IDLE, ps2_data<=1. No pop, so the same byte is retransmitted in full after inhibit drops.
  - In state 11: completes normally.
  - In IDLE: no start.
- Flush[i]: in the same cycle (not tick-gated), pointers<=0, level<=0, overflow<=0, state<=IDLE, ps2_data<=1. Flush beats a simultaneous wr[i] (byte dropped, overflow not set).
- Channels are fully independent apart from the shared tick. Level arithmetic is FIFO_BITS+1 wide, and pointers wrap modulo 2**FIFO_BITS.

Test Plan:
- Reset, PS2DIV=2, FIFO_BITS=3: all ps2_clk/ps2_data=1, fifo_empty=all 1, level=0; one tick every 6 cycles.
- Write 0x1C on ch0 -> frame on ps2_data[0] sampled on ps2_clk falls: 0, 0,0,1,1,1,0,0,0, parity 0, stop 1. Level goes 1->0 at state 11; ps2_clk[0] stays high afterwards; ch1 is idle throughout.
- Write 9 bytes 0x00..0x08 to ch1 in consecutive cycles -> fifo_full=1 at level 8, 0x08 dropped, overflow[1]=1. The 8 frames carry 0x00..0x07; 0x00 has parity 1.
- Write 0xAA, assert inhibit[0] during state 5 for 20 cycles -> ps2_data=1 and clk held high. After release, the full 0xAA frame is resent and level drops only after that frame.
- Flush[1] concurrent with wr[1] while mid-frame and overflow=1 -> next cycle level=0, overflow=0, busy=0, ps2_data=1, and no further frame.
- CHANNELS=4, FIFO_BITS=2: simultaneous writes 0x11/0x22/0x33/0x44 on all channels -> four frames start on the same tick with correct per-channel data.

Source files
------------

// File: rtl/ps2_dev_tx.sv
// Multi-channel PS/2 device-side transmitter: per-channel byte FIFO feeding an
// 11-bit frame serialiser, all channels paced by one shared bit-clock divider.
module ps2_dev_tx #(
  parameter int CHANNELS  = 2,
  parameter int FIFO_BITS = 3,
  parameter int PS2DIV    = 100
) (
  input  logic                              clk_sys,
  input  logic                              reset_n,
  input  logic [CHANNELS-1:0]               wr,
  input  logic [8*CHANNELS-1:0]             wr_data,
  input  logic [CHANNELS-1:0]               flush,
  input  logic [CHANNELS-1:0]               inhibit,
  output logic [CHANNELS-1:0]               ps2_clk,
  output logic [CHANNELS-1:0]               ps2_data,
  output logic [CHANNELS-1:0]               fifo_full,
  output logic [CHANNELS-1:0]               fifo_empty,
  output logic [(FIFO_BITS+1)*CHANNELS-1:0] fifo_level,
  output logic [CHANNELS-1:0]               overflow,
  output logic [CHANNELS-1:0]               busy
);
  localparam int DEPTH = 2**FIFO_BITS;
  localparam int LVL_W = FIFO_BITS + 1;
  localparam int CNT_W = (PS2DIV < 1) ? 1 : $clog2(PS2DIV + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PS2DIV);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [3:0]       ST_IDLE   = 4'd0;
  localparam logic [3:0]       ST_LAST   = 4'd8;
  localparam logic [3:0]       ST_PARITY = 4'd9;
  localparam logic [3:0]       ST_STOP   = 4'd10;
  localparam logic [3:0]       ST_DONE   = 4'd11;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_ps2_q, clk_ps2_d;
  logic             clk_ps2_prev_q, clk_ps2_prev_d;
  logic             tick;

  always_comb begin
    cnt_d          = cnt_q + 1'b1;
    clk_ps2_d      = clk_ps2_q;
    clk_ps2_prev_d = clk_ps2_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d     = '0;
      clk_ps2_d = ~clk_ps2_q;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q          <= '0;
      clk_ps2_q      <= 1'b0;
      clk_ps2_prev_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      clk_ps2_q      <= clk_ps2_d;
      clk_ps2_prev_q <= clk_ps2_prev_d;
    end
  end

  // Rising edge of the divided clock: every serialiser advances on this pulse.
  assign tick = clk_ps2_q & ~clk_ps2_prev_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [7:0]           mem_q [DEPTH];
    logic [FIFO_BITS-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 ovf_q, ovf_d;
    logic [3:0]           state_q, state_d;
    logic [7:0]           shreg_q, shreg_d;
    logic                 par_q, par_d, data_q, data_d;
    logic                 full, empty, push, pop, start;
    logic                 clk_o, busy_o;
    logic [7:0]           wbyte;

    assign wbyte = wr_data[8*i +: 8];
    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    assign push  = wr[i] & ~full & ~flush[i];
    assign start = ~empty & ~inhibit[i];

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
    end

    always_comb begin
      state_d = state_q;
      if (flush[i]) begin
        state_d = ST_IDLE;
      end else if (tick) begin
        if (state_q == ST_IDLE)       state_d = start ? 4'd1 : ST_IDLE;
        else if (state_q == ST_DONE)  state_d = ST_IDLE;
        else if (state_q <= ST_STOP)  state_d = inhibit[i] ? ST_IDLE : state_q + 4'd1;
        else                          state_d = ST_IDLE;
      end
    end

    always_comb begin
      clk_o  = clk_ps2_q | (state_q == ST_IDLE) | inhibit[i];
      busy_o = (state_q != ST_IDLE);
    end

    // Serialiser datapath: a host inhibit mid-frame drops back to a released line.
    always_comb begin
      shreg_d = shreg_q;
      par_d   = par_q;
      data_d  = data_q;
      pop     = 1'b0;
      if (flush[i]) begin
        data_d = 1'b1;
      end else if (tick) begin
        if (state_q == ST_IDLE) begin
          if (start) begin
            shreg_d = mem_q[rptr_q];
            par_d   = 1'b1;
            data_d  = 1'b0;
          end
        end else if (state_q == ST_DONE) begin
          pop = 1'b1;
        end else if (inhibit[i] || state_q > ST_STOP) begin
          data_d = 1'b1;
        end else if (state_q <= ST_LAST) begin
          data_d  = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
          par_d   = par_q ^ shreg_q[0];
        end else if (state_q == ST_PARITY) begin
          data_d = par_q;
        end else begin
          data_d = 1'b1;
        end
      end
    end

    always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      ovf_d   = ovf_q;
      if (flush[i]) begin
        wptr_d  = '0;
        rptr_d  = '0;
        level_d = '0;
        ovf_d   = 1'b0;
      end else begin
        if (wr[i] && full) ovf_d = 1'b1;
        if (push)          wptr_d = wptr_q + 1'b1;
        if (pop)           rptr_d = rptr_q + 1'b1;
        if (push && !pop)  level_d = level_q + 1'b1;
        if (pop && !push)  level_d = level_q - 1'b1;
      end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        level_q <= '0;
        ovf_q   <= 1'b0;
        shreg_q <= '0;
        par_q   <= 1'b0;
        data_q  <= 1'b1;
      end else begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        level_q <= level_d;
        ovf_q   <= ovf_d;
        shreg_q <= shreg_d;
        par_q   <= par_d;
        data_q  <= data_d;
      end
    end

    always_ff @(posedge clk_sys) begin
      if (push) mem_q[wptr_q] <= wbyte;
    end

    assign ps2_clk[i]                   = clk_o;
    assign busy[i]                      = busy_o;
    assign ps2_data[i]                  = data_q;
    assign fifo_full[i]                 = full;
    assign fifo_empty[i]                = empty;
    assign overflow[i]                  = ovf_q;
    assign fifo_level[LVL_W*i +: LVL_W] = level_q;
  end
endmodule

// File: tb/tb_ps2_dev_tx.sv
// Bench for ps2_dev_tx: two instances (2ch/depth 8 and 4ch/depth 4) share a
// frame monitor that decodes each PS/2 line and compares against byte queues.
module tb_ps2_dev_tx;
  localparam int PS2DIV = 2;
  localparam int PERIOD = 2 * (PS2DIV + 1);

  logic clk_sys = 1'b0;
  logic reset_n;
  always #5 clk_sys = ~clk_sys;

  logic [1:0]  a_wr, a_flush, a_inh, a_clk, a_dat, a_full, a_empty, a_ovf, a_busy;
  logic [15:0] a_wdata;
  logic [7:0]  a_level;
  logic [3:0]  b_wr, b_flush, b_inh, b_clk, b_dat, b_full, b_empty, b_ovf, b_busy;
  logic [31:0] b_wdata;
  logic [11:0] b_level;

  ps2_dev_tx #(.CHANNELS(2), .FIFO_BITS(3), .PS2DIV(PS2DIV)) u_dut_a (
    .clk_sys(clk_sys), .reset_n(reset_n), .wr(a_wr), .wr_data(a_wdata),
    .flush(a_flush), .inhibit(a_inh), .ps2_clk(a_clk), .ps2_data(a_dat),
    .fifo_full(a_full), .fifo_empty(a_empty), .fifo_level(a_level),
    .overflow(a_ovf), .busy(a_busy));

  ps2_dev_tx #(.CHANNELS(4), .FIFO_BITS(2), .PS2DIV(PS2DIV)) u_dut_b (
    .clk_sys(clk_sys), .reset_n(reset_n), .wr(b_wr), .wr_data(b_wdata),
    .flush(b_flush), .inhibit(b_inh), .ps2_clk(b_clk), .ps2_data(b_dat),
    .fifo_full(b_full), .fifo_empty(b_empty), .fifo_level(b_level),
    .overflow(b_ovf), .busy(b_busy));

  // Monitor channels 0..1 map to instance A, 2..5 to instance B.
  logic [5:0]  m_clk, m_dat, m_busy;
  assign m_clk  = {b_clk, a_clk};
  assign m_dat  = {b_dat, a_dat};
  assign m_busy = {b_busy, a_busy};

  logic [7:0]  sbq [6][$];
  logic [10:0] bits [6];
  logic [5:0]  prev_clk;
  logic [5:0]  busy_seen;
  int          mon_n [6];
  int          since_fall [6];
  int          frames_rx [6];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic monitor_step();
    logic [7:0] eb;
    for (int g = 0; g < 6; g++) begin
      busy_seen[g] = busy_seen[g] | m_busy[g];
      if (!reset_n || !m_busy[g]) begin
        mon_n[g] = 0;
        prev_clk[g] = 1'b1;
        since_fall[g] = 0;
      end else begin
        since_fall[g]++;
        if (prev_clk[g] && !m_clk[g]) begin
          if (mon_n[g] > 0) check_eq($sformatf("bit_period_ch%0d", g), since_fall[g], PERIOD);
          since_fall[g] = 0;
          bits[g][mon_n[g]] = m_dat[g];
          mon_n[g]++;
          if (mon_n[g] == 11) begin
            check_eq($sformatf("sb_has_entry_ch%0d", g), sbq[g].size() != 0, 1);
            if (sbq[g].size() != 0) begin
              eb = sbq[g].pop_front();
              check_eq($sformatf("frame_ch%0d", g), bits[g], {1'b1, ~^eb, eb, 1'b0});
            end
            frames_rx[g]++;
            mon_n[g] = 0;
          end
        end
        prev_clk[g] = m_clk[g];
      end
    end
  endtask

  task automatic wait_frames(input int g, input int target, input int budget);
    int t = 0;
    while (frames_rx[g] < target && t < budget) begin @(negedge clk_sys); t++; end
    check_eq($sformatf("frames_ch%0d", g), frames_rx[g], target);
  endtask

  task automatic wait_idle(input int g, input int budget);
    int t = 0;
    while (m_busy[g] && t < budget) begin @(negedge clk_sys); t++; end
    check_eq($sformatf("idle_ch%0d", g), m_busy[g], 0);
  endtask

  task automatic wait_bit(input int g, input int n, input int budget);
    int t = 0;
    while (mon_n[g] != n && t < budget) begin @(negedge clk_sys); t++; end
    check_eq($sformatf("reach_bit_ch%0d", g), mon_n[g], n);
  endtask

  initial begin
    int r;
    logic clk_low_seen;
    reset_n = 1'b0;
    a_wr = '0; a_wdata = '0; a_flush = '0; a_inh = '0;
    b_wr = '0; b_wdata = '0; b_flush = '0; b_inh = '0;
    prev_clk = '1; busy_seen = '0;
    for (int k = 0; k < 6; k++) begin
      mon_n[k] = 0; since_fall[k] = 0; frames_rx[k] = 0; bits[k] = '0;
    end
    repeat (3) @(negedge clk_sys);
    check_eq("rst_a_clk", a_clk, 2'b11);
    check_eq("rst_a_dat", a_dat, 2'b11);
    check_eq("rst_a_empty", a_empty, 2'b11);
    check_eq("rst_a_full", a_full, 2'b00);
    check_eq("rst_a_level", a_level, 8'h00);
    check_eq("rst_a_ovf_busy", {a_ovf, a_busy}, 4'h0);
    check_eq("rst_b_clk_dat", {b_clk, b_dat}, 8'hFF);
    check_eq("rst_b_empty_level", {b_empty, b_level}, 16'hF000);
    reset_n = 1'b1;
    fork
      forever begin @(negedge clk_sys); monitor_step(); end
    join_none

    // Single byte on ch0; ch1 must stay quiet.
    @(negedge clk_sys); a_wr = 2'b01; a_wdata[7:0] = 8'h1C; sbq[0].push_back(8'h1C);
    @(negedge clk_sys); a_wr = 2'b00;
    check_eq("t1_level_after_wr", a_level[3:0], 4'd1);
    check_eq("t1_empty", a_empty[0], 1'b0);
    wait_frames(0, 1, 200);
    check_eq("t1_level_before_pop", a_level[3:0], 4'd1);
    wait_idle(0, 40);
    check_eq("t1_level_after_pop", a_level[3:0], 4'd0);
    repeat (12) @(negedge clk_sys);
    check_eq("t1_clk_idle_high", a_clk[0], 1'b1);
    check_eq("t1_ch1_never_busy", busy_seen[1], 1'b0);

    // Fill ch1 past its depth of 8.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk_sys); a_wr = 2'b10; a_wdata[15:8] = 8'(k);
      if (k < 8) sbq[1].push_back(8'(k));
    end
    @(negedge clk_sys); a_wr = 2'b00;
    check_eq("t2_full", a_full, 2'b10);
    check_eq("t2_level", a_level[7:4], 4'd8);
    check_eq("t2_ovf", a_ovf, 2'b10);
    wait_frames(1, 8, 1500);
    wait_idle(1, 40);
    check_eq("t2_drained", {a_empty[1], a_level[7:4]}, 5'b10000);
    check_eq("t2_ovf_sticky", a_ovf[1], 1'b1);

    // Host inhibit mid-frame, then a full retransmission.
    @(negedge clk_sys); a_wr = 2'b01; a_wdata[7:0] = 8'hAA; sbq[0].push_back(8'hAA);
    @(negedge clk_sys); a_wr = 2'b00;
    wait_bit(0, 5, 200);
    r = frames_rx[0];
    a_inh = 2'b01;
    clk_low_seen = 1'b0;
    repeat (20) begin @(negedge clk_sys); clk_low_seen = clk_low_seen | ~a_clk[0]; end
    check_eq("t3_clk_held_high", clk_low_seen, 1'b0);
    check_eq("t3_aborted", {a_dat[0], a_busy[0]}, 2'b10);
    check_eq("t3_no_pop", a_level[3:0], 4'd1);
    a_inh = 2'b00;
    wait_frames(0, r + 1, 300);
    check_eq("t3_level_before_pop", a_level[3:0], 4'd1);
    wait_idle(0, 40);
    check_eq("t3_level_after_pop", a_level[3:0], 4'd0);

    // Flush ch1 mid-frame with a simultaneous write, overflow still set.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys); a_wr = 2'b10; a_wdata[15:8] = 8'h5A + 8'(k); sbq[1].push_back(8'h5A + 8'(k));
    end
    @(negedge clk_sys); a_wr = 2'b00;
    wait_bit(1, 4, 200);
    a_flush = 2'b10; a_wr = 2'b10; a_wdata[15:8] = 8'h55;
    @(negedge clk_sys); a_flush = 2'b00; a_wr = 2'b00;
    check_eq("t4_level", a_level[7:4], 4'd0);
    check_eq("t4_ovf_cleared", a_ovf, 2'b00);
    check_eq("t4_idle_line", {a_busy[1], a_dat[1], a_empty[1]}, 3'b011);
    sbq[1].delete();
    r = frames_rx[1];
    busy_seen[1] = 1'b0;
    repeat (150) @(negedge clk_sys);
    check_eq("t4_no_more_frames", frames_rx[1], r);
    check_eq("t4_stays_idle", {busy_seen[1], a_level[7:4]}, 5'b00000);

    // Four channels written together start on the same tick.
    @(negedge clk_sys); b_wr = 4'hF; b_wdata = 32'h44332211;
    sbq[2].push_back(8'h11); sbq[3].push_back(8'h22);
    sbq[4].push_back(8'h33); sbq[5].push_back(8'h44);
    @(negedge clk_sys); b_wr = 4'h0;
    check_eq("t5_levels", b_level, 12'h249);
    r = 0;
    while (b_busy == 4'h0 && r < 20) begin @(negedge clk_sys); r++; end
    check_eq("t5_same_tick", b_busy, 4'hF);
    for (int g = 2; g < 6; g++) wait_frames(g, 1, 200);
    for (int g = 2; g < 6; g++) wait_idle(g, 40);
    check_eq("t5_drained", {b_empty, b_level}, 16'hF000);

    // Depth-4 boundary on instance B ch0.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_sys); b_wr = 4'h1; b_wdata[7:0] = 8'hC0 + 8'(k);
      if (k < 4) sbq[2].push_back(8'hC0 + 8'(k));
    end
    @(negedge clk_sys); b_wr = 4'h0;
    check_eq("t6_full", b_full, 4'h1);
    check_eq("t6_level", b_level[2:0], 3'd4);
    check_eq("t6_ovf", b_ovf, 4'h1);
    wait_frames(2, 5, 1200);
    wait_idle(2, 40);
    check_eq("t6_drained", {b_empty[0], b_level[2:0]}, 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
